// File: rtl/frame_buf_pkg.sv
// Shared definitions for the ping-pong frame buffer: bank state encoding
// and default sizing parameters.
package frame_buf_pkg;

    // Occupancy of one frame bank
    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    localparam int DEF_DATA_WIDTH   = 24;
    localparam int DEF_FRAME_PIXELS = 16;

endpackage

// File: rtl/fb_ram.sv
// Single-clock simple dual-port RAM with a registered read port.
// The read register is resettable so the buffer output starts at zero,
// and it holds its value when no read is issued.
module fb_ram #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 32,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: array contents are never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port: updates only on a read, otherwise holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/frame_buf_pp.sv
// Ping-pong frame buffer: two banks of FRAME_PIXELS words. The writer fills
// one EMPTY bank while the reader drains the other FULL bank. In repeat mode
// the reader replays the last frame until a newer frame is complete.
//
// Handshake: wr_ready / rd_ready depend only on registered bank state. A
// write (read) is accepted on a rising edge where wr_en_in && wr_ready
// (rd_en_in && rd_ready). A refused request has no effect other than a
// one-cycle overflow (underflow) pulse the following cycle. Read data
// appears on data_out with data_valid one cycle after the accepted request.
module frame_buf_pp
    import frame_buf_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
    parameter int ADDR_WIDTH   = $clog2(FRAME_PIXELS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en_in,
    input  logic                  rpt_en_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  wr_ready,
    output logic                  rd_ready,
    output logic                  rd_sof,
    output logic                  overflow,
    output logic                  underflow,
    // Internal state exposed for observation
    output logic [1:0]            dbg_bank_full,
    output logic                  dbg_wr_bank,
    output logic                  dbg_rd_bank,
    output logic [ADDR_WIDTH-1:0] dbg_wr_cnt,
    output logic [ADDR_WIDTH-1:0] dbg_rd_cnt
);

    localparam int RAM_DEPTH = 2 * FRAME_PIXELS;
    localparam int RAM_AW    = $clog2(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(FRAME_PIXELS - 1);
    localparam logic [RAM_AW-1:0]     BANK1_BASE = RAM_AW'(FRAME_PIXELS);

    bank_state_e           bank_q [2];
    bank_state_e           bank_d [2];
    logic                  wr_bank;
    logic                  rd_bank;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] rd_cnt;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  wr_done;
    logic                  rd_last;
    logic                  rd_release;
    logic [RAM_AW-1:0]     ram_waddr;
    logic [RAM_AW-1:0]     ram_raddr;

    assign wr_ready = (bank_q[wr_bank] == BANK_EMPTY);
    assign rd_ready = (bank_q[rd_bank] == BANK_FULL);
    assign wr_acc   = wr_en_in && wr_ready;
    assign rd_acc   = rd_en_in && rd_ready;
    assign wr_done  = wr_acc && (wr_cnt == LAST_IDX);
    assign rd_last  = rd_acc && (rd_cnt == LAST_IDX);
    // Leave the bank unless repeating is requested and no newer frame waits
    assign rd_release = rd_last && (!rpt_en_in || (bank_q[~rd_bank] == BANK_FULL));

    assign ram_waddr = (wr_bank ? BANK1_BASE : '0) + RAM_AW'(wr_cnt);
    assign ram_raddr = (rd_bank ? BANK1_BASE : '0) + RAM_AW'(rd_cnt);

    assign dbg_bank_full = {bank_q[1] == BANK_FULL, bank_q[0] == BANK_FULL};
    assign dbg_wr_bank   = wr_bank;
    assign dbg_rd_bank   = rd_bank;
    assign dbg_wr_cnt    = wr_cnt;
    assign dbg_rd_cnt    = rd_cnt;

    // Next bank state: a completed write fills, a released read frees.
    // Both can happen in one cycle only on opposite banks.
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        if (wr_done) begin
            bank_d[wr_bank] = BANK_FULL;
        end
        if (rd_release) begin
            bank_d[rd_bank] = BANK_EMPTY;
        end
    end

    // Bank state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_q[0] <= BANK_EMPTY;
            bank_q[1] <= BANK_EMPTY;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
        end
    end

    // Write pointer and pixel counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
        end else if (wr_acc) begin
            if (wr_done) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // Read pointer and pixel counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
        end else if (rd_acc) begin
            if (rd_last) begin
                rd_cnt <= '0;
            end else begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (rd_release) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Status pulses aligned with the registered read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_valid <= 1'b0;
            rd_sof     <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            data_valid <= rd_acc;
            rd_sof     <= rd_acc && (rd_cnt == '0);
            overflow   <= wr_en_in && !wr_ready;
            underflow  <= rd_en_in && !rd_ready;
        end
    end

    fb_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RAM_DEPTH),
        .AW         (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset),
        .we    (wr_acc),
        .waddr (ram_waddr),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (ram_raddr),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_frame_buf_pp.sv
// Directed testbench for frame_buf_pp with FRAME_PIXELS=4.
module tb_frame_buf_pp;

    localparam int DW = 24;
    localparam int FP = 4;
    localparam int AW = 2;

    logic          clk;
    logic          reset;
    logic          wr_en_in;
    logic [DW-1:0] data_in;
    logic          rd_en_in;
    logic          rpt_en_in;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          wr_ready;
    logic          rd_ready;
    logic          rd_sof;
    logic          overflow;
    logic          underflow;
    logic [1:0]    dbg_bank_full;
    logic          dbg_wr_bank;
    logic          dbg_rd_bank;
    logic [AW-1:0] dbg_wr_cnt;
    logic [AW-1:0] dbg_rd_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    frame_buf_pp #(
        .DATA_WIDTH   (DW),
        .FRAME_PIXELS (FP),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en_in      (wr_en_in),
        .data_in       (data_in),
        .rd_en_in      (rd_en_in),
        .rpt_en_in     (rpt_en_in),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .wr_ready      (wr_ready),
        .rd_ready      (rd_ready),
        .rd_sof        (rd_sof),
        .overflow      (overflow),
        .underflow     (underflow),
        .dbg_bank_full (dbg_bank_full),
        .dbg_wr_bank   (dbg_wr_bank),
        .dbg_rd_bank   (dbg_rd_bank),
        .dbg_wr_cnt    (dbg_wr_cnt),
        .dbg_rd_cnt    (dbg_rd_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reset with inputs idle; outputs are checked while reset is still low
    task automatic apply_reset();
        @(negedge clk);
        wr_en_in  = 1'b0;
        rd_en_in  = 1'b0;
        rpt_en_in = 1'b0;
        data_in   = '0;
        reset     = 1'b0;
        #1;
        check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
        check_eq("rst_rd_ready", 32'(rd_ready), 32'd0);
        check_eq("rst_data_out", 32'(data_out), 32'd0);
        check_eq("rst_data_valid", 32'(data_valid), 32'd0);
        check_eq("rst_bank_full", 32'(dbg_bank_full), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One-cycle write request, starting and ending on a falling edge
    task automatic write_px(input logic [DW-1:0] d);
        wr_en_in = 1'b1;
        data_in  = d;
        @(negedge clk);
        wr_en_in = 1'b0;
        check_eq("wr_overflow", 32'(overflow), 32'd0);
    endtask

    // One-cycle read request with the expected returned pixel
    task automatic read_px(input logic [DW-1:0] d, input logic sof);
        rd_en_in = 1'b1;
        @(negedge clk);
        rd_en_in = 1'b0;
        check_eq("rd_valid", 32'(data_valid), 32'd1);
        check_eq("rd_data", 32'(data_out), 32'(d));
        check_eq("rd_sof", 32'(rd_sof), 32'(sof));
        check_eq("rd_underflow", 32'(underflow), 32'd0);
    endtask

    // A cycle with no requests: every pulse output stays low
    task automatic idle_check(input string tag);
        @(negedge clk);
        check_eq({tag, "_valid"}, 32'(data_valid), 32'd0);
        check_eq({tag, "_sof"}, 32'(rd_sof), 32'd0);
        check_eq({tag, "_ovf"}, 32'(overflow), 32'd0);
        check_eq({tag, "_unf"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        wr_en_in  = 1'b0;
        rd_en_in  = 1'b0;
        rpt_en_in = 1'b0;
        data_in   = '0;

        // Read from an empty buffer is refused
        apply_reset();
        rd_en_in = 1'b1;
        @(negedge clk);
        rd_en_in = 1'b0;
        check_eq("unf_pulse", 32'(underflow), 32'd1);
        check_eq("unf_valid", 32'(data_valid), 32'd0);
        check_eq("unf_data", 32'(data_out), 32'd0);
        idle_check("unf_after");

        // Basic frame write then read
        for (int i = 1; i <= 4; i++) write_px(DW'(i));
        check_eq("basic_rd_ready", 32'(rd_ready), 32'd1);
        check_eq("basic_wr_ready", 32'(wr_ready), 32'd1);
        for (int i = 1; i <= 4; i++) read_px(DW'(i), i == 1);
        idle_check("basic_after");
        check_eq("basic_drained", 32'(rd_ready), 32'd0);
        check_eq("basic_banks", 32'(dbg_bank_full), 32'd0);

        // Fill both banks, then one extra write is dropped
        apply_reset();
        for (int i = 0; i < 8; i++) write_px(DW'(8'h10 + i));
        check_eq("full_wr_ready", 32'(wr_ready), 32'd0);
        check_eq("full_banks", 32'(dbg_bank_full), 32'd3);
        wr_en_in = 1'b1;
        data_in  = DW'(24'h99);
        @(negedge clk);
        wr_en_in = 1'b0;
        check_eq("ovf_pulse", 32'(overflow), 32'd1);
        check_eq("ovf_wr_cnt", 32'(dbg_wr_cnt), 32'd0);
        idle_check("ovf_after");
        for (int i = 0; i < 8; i++) read_px(DW'(8'h10 + i), (i % 4) == 0);
        check_eq("ovf_drained", 32'(rd_ready), 32'd0);

        // Repeat mode replays the only available frame
        apply_reset();
        rpt_en_in = 1'b1;
        for (int i = 5; i <= 8; i++) write_px(DW'(i));
        for (int k = 0; k < 8; k++) read_px(DW'(5 + (k % 4)), (k % 4) == 0);
        check_eq("rpt_still_full", 32'(dbg_bank_full), 32'd1);
        check_eq("rpt_rd_bank", 32'(dbg_rd_bank), 32'd0);
        rpt_en_in = 1'b0;
        for (int i = 5; i <= 8; i++) read_px(DW'(i), i == 5);
        check_eq("rpt_released", 32'(rd_ready), 32'd0);

        // Same-cycle frame completion on both sides
        apply_reset();
        for (int i = 1; i <= 4; i++) write_px(DW'(i));
        for (int i = 0; i < 3; i++) write_px(DW'(8'h20 + i));
        for (int i = 1; i <= 3; i++) read_px(DW'(i), i == 1);
        wr_en_in = 1'b1;
        data_in  = DW'(24'h23);
        rd_en_in = 1'b1;
        @(negedge clk);
        wr_en_in = 1'b0;
        rd_en_in = 1'b0;
        check_eq("both_valid", 32'(data_valid), 32'd1);
        check_eq("both_data", 32'(data_out), 32'd4);
        check_eq("both_banks", 32'(dbg_bank_full), 32'd2);
        check_eq("both_wr_ready", 32'(wr_ready), 32'd1);
        check_eq("both_rd_bank", 32'(dbg_rd_bank), 32'd1);
        write_px(DW'(24'h30));
        check_eq("both_next_wr_cnt", 32'(dbg_wr_cnt), 32'd1);
        check_eq("both_next_wr_bank", 32'(dbg_wr_bank), 32'd0);
        for (int i = 0; i < 4; i++) read_px(DW'(8'h20 + i), i == 0);
        check_eq("both_drained", 32'(rd_ready), 32'd0);

        // Reset in the middle of a frame discards the partial frame
        apply_reset();
        write_px(DW'(24'hA1));
        write_px(DW'(24'hA2));
        check_eq("mid_wr_cnt_pre", 32'(dbg_wr_cnt), 32'd2);
        reset = 1'b0;
        #2;
        check_eq("mid_wr_cnt", 32'(dbg_wr_cnt), 32'd0);
        check_eq("mid_rd_ready", 32'(rd_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) write_px(DW'(8'h40 + i));
        check_eq("mid_not_yet", 32'(rd_ready), 32'd0);
        write_px(DW'(24'h43));
        check_eq("mid_frame_ready", 32'(rd_ready), 32'd1);
        check_eq("mid_banks", 32'(dbg_bank_full), 32'd1);
        for (int i = 0; i < 4; i++) read_px(DW'(8'h40 + i), i == 0);
        idle_check("mid_after");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
